schoolbook_div: RTL and testbench
=================================

# schoolbook_div

Bit-serial restoring long divider that undoes the schoolbook shift-add multiplier. It takes a double-width dividend, for example a product, and a single-width divisor. It produces one quotient bit per clock, MSB first, over NW cycles. It sits beside the multiplier in the large-integer library and is used for modular reduction and for checking products.

## Interface

Parameters:
- NW, 1042, dividend and quotient width in bits.
- DW, 521, divisor and remainder width in bits. Requires NW >= DW >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low; 0 resets all state immediately.
- start  input  1  request a division; sampled on the rising edge.
- n  input  NW  dividend; sampled only when start is accepted.
- d  input  DW  divisor; sampled only when start is accepted.
- q  output  NW  quotient, registered.
- r  output  DW  remainder, registered.
- busy  output  1  division in progress.
- done  output  1  one-cycle pulse: q, r and dbz are final.
- dbz  output  1  last accepted division had d == 0.

## Operation

- Reset values: q = 0, r = 0, busy = 0, done = 0, dbz = 0, state IDLE, count = 0.
- State machine:
  - IDLE, entered on reset. start=1 and d != 0 -> RUN. start=1 and d == 0 -> ZERO. Otherwise stay.
  - RUN runs for exactly NW iterations, then moves to FIN.
  - ZERO moves to FIN on the next edge.
  - FIN asserts done for one cycle. start=1 in FIN is accepted exactly as in IDLE. Otherwise go to IDLE.
- Accepting start:
  - Latch d into a DW-bit divisor register.
  - Latch n into an NW-bit dividend shift register.
  - Clear the (DW+1)-bit partial remainder P and the quotient shift register.
  - Set count = 0, busy = 1, dbz = 0.
- Each RUN iteration:
  - T = {P[DW-1:0], msb of dividend register}.
  - If T >= {1'b0, D}: P = T − D and quotient bit = 1. Otherwise: P = T and quotient bit = 0.
  - Shift the dividend register left by 1. Shift the quotient bit into the quotient register LSB. count = count + 1.
  - After iteration NW (count == NW−1 at that edge):
    - q = quotient register.
    - r = P[DW-1:0]; P[DW] is always 0 here.
    - busy = 0, done = 1.
- ZERO path:
  - q = all ones (NW'b1…1), r = n[DW-1:0], dbz = 1.
  - busy stays 1 for that cycle. On the FIN edge: busy = 0, done = 1.
- Invariant: n == q*d + r and r < d whenever d != 0.
- start while busy = 1 is ignored. The inputs n and d are don't-care during RUN.
- q, r and dbz hold their values from the last completed division until the next one completes. Accepting a new start does not clear them.
- Only one subtractor of DW+1 bits is used; there is no combinational path from n or d to the outputs.
- count is $clog2(NW) bits wide and never wraps in RUN.

## Timing

- start accepted at edge E0. Iterations occur at edges E1 … E_NW.
- q, r valid and done = 1 after edge E_NW: latency NW cycles (1042 at the default). done drops after edge E_NW+1.
- busy = 1 from after E0 up to and including the cycle before done.
- Divide by zero: done = 1 after edge E1, so latency is 1 cycle.
- Back-to-back operation:
  - start = 1 during the done cycle is accepted at the next edge. done falls and busy rises on that edge.
  - Throughput is one division every NW+1 cycles.
- Asynchronous reset asserted mid-RUN:
  - All outputs take their reset values immediately and the partial result is discarded.
  - After rst deasserts, the first start begins a clean division.

## Test plan

- NW=8, DW=4: n=200, d=7, start for 1 cycle -> done exactly 8 cycles later with q=28, r=4, dbz=0. busy is high for the 8 cycles before done.
- NW=8, DW=4: n=3, d=9 (n < d) -> q=0, r=3. Then n=255, d=15 -> q=17, r=0. Run these back to back, with start held high during the done cycle.
- NW=8, DW=4: n=0xA5, d=0 -> done 1 cycle after start with q=0xFF, r=0x5, dbz=1. Then n=16, d=1 -> q=16, r=0, dbz=0.
- Defaults: n = (2^521−1)^2, d = 2^521−1 -> q = 2^521−1, r = 0 after 1042 cycles.
  - Also run 1000 random (n, d) pairs against a reference model, including d = 2^520 and d = 2^521−1.
- Pulse start again at cycles 3 and 5 of a run with different n and d -> ignored; the first division's result is unchanged and done appears once.
- Drop rst at cycle 4 of a run -> q, r, busy, done, dbz all 0 immediately. After release, no done appears until a new start, which completes normally.

Source files
------------

// File: rtl/schoolbook_div.sv
// schoolbook_div: bit-serial restoring long divider, one quotient bit per clock, MSB first.
// Divides an NW-bit dividend by a DW-bit divisor in NW cycles; divide-by-zero completes in 1 cycle.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   start - request a division (accepted in IDLE or FIN)
//   n, d  - dividend / divisor, sampled when start is accepted
//   q, r  - registered quotient / remainder of the last completed division
//   busy  - division in progress
//   done  - one-cycle pulse when q, r, dbz are final
//   dbz   - last division had d == 0
module schoolbook_div #(
    parameter int unsigned NW = 1042,
    parameter int unsigned DW = 521
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic [DW-1:0] d,
    output logic [NW-1:0] q,
    output logic [DW-1:0] r,
    output logic          busy,
    output logic          done,
    output logic          dbz
);

    localparam int unsigned CW = $clog2(NW);

    typedef enum logic [1:0] {IDLE, RUN, ZERO, FIN} state_t;

    state_t        state, state_nxt;
    logic [NW-1:0] nreg, nreg_nxt;
    logic [DW-1:0] dreg, dreg_nxt;
    logic [DW:0]   p, p_nxt;
    logic [NW-1:0] qreg, qreg_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [NW-1:0] q_nxt;
    logic [DW-1:0] r_nxt;
    logic          busy_nxt, done_nxt, dbz_nxt;

    // One restoring step: the single (DW+1)-bit subtraction and its select.
    // P[DW] is always 0 between steps, so dropping it when forming T loses nothing.
    logic [DW:0]   t;
    logic [DW+1:0] sub;
    logic          ge;
    logic [DW:0]   p_it;
    logic [NW-1:0] q_it;

    always_comb begin
        t    = (DW+1)'({p, nreg[NW-1]});
        sub  = {1'b0, t} - {2'b00, dreg};
        ge   = ~sub[DW+1];
        p_it = ge ? sub[DW:0] : t;
        q_it = NW'({qreg, ge});
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        nreg_nxt  = nreg;
        dreg_nxt  = dreg;
        p_nxt     = p;
        qreg_nxt  = qreg;
        count_nxt = count;
        q_nxt     = q;
        r_nxt     = r;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        dbz_nxt   = dbz;

        unique case (state)
            IDLE, FIN: begin
                state_nxt = IDLE;
                if (start) begin
                    dreg_nxt  = d;
                    nreg_nxt  = n;
                    p_nxt     = '0;
                    qreg_nxt  = '0;
                    count_nxt = '0;
                    busy_nxt  = 1'b1;
                    dbz_nxt   = 1'b0;
                    state_nxt = (d == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                p_nxt    = p_it;
                nreg_nxt = NW'({nreg, 1'b0});
                qreg_nxt = q_it;
                if (count == CW'(NW - 1)) begin
                    q_nxt     = q_it;
                    r_nxt     = p_it[DW-1:0];
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end else begin
                    count_nxt = CW'(count + 1'b1);
                end
            end
            ZERO: begin
                // Saturated quotient, dividend low bits as remainder.
                q_nxt     = '1;
                r_nxt     = nreg[DW-1:0];
                dbz_nxt   = 1'b1;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = FIN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            nreg  <= '0;
            dreg  <= '0;
            p     <= '0;
            qreg  <= '0;
            count <= '0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nxt;
            nreg  <= nreg_nxt;
            dreg  <= dreg_nxt;
            p     <= p_nxt;
            qreg  <= qreg_nxt;
            count <= count_nxt;
            q     <= q_nxt;
            r     <= r_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            dbz   <= dbz_nxt;
        end
    end

endmodule

// File: tb/tb_schoolbook_div.sv
// tb_schoolbook_div: bench for schoolbook_div with a small (NW=8, DW=4) and a default-size instance.
module tb_schoolbook_div;

    localparam int unsigned SN = 8;
    localparam int unsigned SD = 4;
    localparam int unsigned WN = 1042;
    localparam int unsigned WD = 521;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          s_start = 1'b0;
    logic [SN-1:0] s_n = '0, s_q;
    logic [SD-1:0] s_d = '0, s_r;
    logic          s_busy, s_done, s_dbz;

    logic          w_start = 1'b0;
    logic [WN-1:0] w_n = '0, w_q;
    logic [WD-1:0] w_d = '0, w_r;
    logic          w_busy, w_done, w_dbz;

    schoolbook_div #(.NW(SN), .DW(SD)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .n(s_n), .d(s_d),
        .q(s_q), .r(s_r), .busy(s_busy), .done(s_done), .dbz(s_dbz)
    );

    schoolbook_div u_wide (
        .clk(clk), .rst(rst), .start(w_start), .n(w_n), .d(w_d),
        .q(w_q), .r(w_r), .busy(w_busy), .done(w_done), .dbz(w_dbz)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [SN-1:0] q; logic [SD-1:0] r; logic dbz; } exp_s_t;
    typedef struct { logic [WN-1:0] q; logic [WD-1:0] r; } exp_w_t;
    exp_s_t sq[$];
    exp_w_t wq[$];

    function automatic exp_s_t model_s(logic [SN-1:0] nn, logic [SD-1:0] dd);
        exp_s_t e;
        if (dd == '0) begin
            e.q = '1; e.r = nn[SD-1:0]; e.dbz = 1'b1;
        end else begin
            e.q = nn / SN'(dd); e.r = SD'(nn % SN'(dd)); e.dbz = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_s_t pop_s();
        exp_s_t e;
        if (sq.size() == 0) begin
            e.q = 'x; e.r = 'x; e.dbz = 1'bx;
        end else e = sq.pop_front();
        return e;
    endfunction

    function automatic exp_w_t pop_w();
        exp_w_t e;
        if (wq.size() == 0) begin
            e.q = 'x; e.r = 'x;
        end else e = wq.pop_front();
        return e;
    endfunction

    // Drive a start on the small instance from a negedge; returns at the negedge after acceptance.
    task automatic launch_s(input logic [SN-1:0] nn, input logic [SD-1:0] dd);
        s_n = nn; s_d = dd; s_start = 1'b1;
        sq.push_back(model_s(nn, dd));
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic launch_w(input logic [WN-1:0] nn, input logic [WD-1:0] dd);
        exp_w_t e;
        e.q = nn / WN'(dd);
        e.r = WD'(nn % WN'(dd));
        w_n = nn; w_d = dd; w_start = 1'b1;
        wq.push_back(e);
        @(negedge clk);
        w_start = 1'b0;
    endtask

    // Bounded wait for done; cyc = cycles after acceptance, bcnt = busy samples before done.
    task automatic wait_s(input int limit, output int cyc, output int bcnt);
        cyc = 0; bcnt = 0;
        while (s_done !== 1'b1 && cyc < limit) begin
            if (s_busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_w(input int limit, output int cyc);
        cyc = 0;
        while (w_done !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({s_q, s_r, s_busy, s_done, s_dbz} !== '0 || {w_q, w_r, w_busy, w_done, w_dbz} !== '0) begin
            n_fail++;
            $display("FAIL reset_state small q=%h r=%h busy=%b done=%b dbz=%b, wide busy=%b done=%b, required all 0",
                     s_q, s_r, s_busy, s_done, s_dbz, w_busy, w_done, w_dbz);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc, bc;
        exp_s_t e;
        launch_s(8'd200, 4'd7);
        wait_s(20, cyc, bc);
        e = pop_s();
        n_tests++;
        if (s_done !== 1'b1 || cyc != 8) begin
            n_fail++; $display("FAIL basic_latency got %0d cycles (done=%b), required 8", cyc, s_done);
        end
        n_tests++;
        if (bc != 8) begin
            n_fail++; $display("FAIL basic_busy busy high %0d cycles, required 8", bc);
        end
        n_tests++;
        if ({s_q, s_r, s_dbz} !== {e.q, e.r, e.dbz}) begin
            n_fail++; $display("FAIL basic_result q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                               s_q, s_r, s_dbz, e.q, e.r, e.dbz);
        end
        n_tests++;
        if (s_q !== 8'd28 || s_r !== 4'd4) begin
            n_fail++; $display("FAIL basic_const q=%0d r=%0d, required q=28 r=4", s_q, s_r);
        end
        @(negedge clk);
        n_tests++;
        if (s_done !== 1'b0 || s_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_pulse done=%b busy=%b, required 0 0", s_done, s_busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        exp_s_t e;
        launch_s(8'd3, 4'd9);
        wait_s(20, cyc, bc);
        e = pop_s();
        n_tests++;
        if (s_done !== 1'b1 || {s_q, s_r, s_dbz} !== {e.q, e.r, e.dbz} || s_q !== 8'd0 || s_r !== 4'd3) begin
            n_fail++; $display("FAIL b2b_first done=%b q=%0d r=%0d, required done=1 q=0 r=3", s_done, s_q, s_r);
        end
        launch_s(8'd255, 4'd15);
        n_tests++;
        if (s_done !== 1'b0 || s_busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_handover done=%b busy=%b, required 0 1", s_done, s_busy);
        end
        wait_s(20, cyc, bc);
        e = pop_s();
        n_tests++;
        if (s_done !== 1'b1 || cyc != 8 || {s_q, s_r, s_dbz} !== {e.q, e.r, e.dbz} || s_q !== 8'd17 || s_r !== 4'd0) begin
            n_fail++; $display("FAIL b2b_second cyc=%0d q=%0d r=%0d, required cyc=8 q=17 r=0", cyc, s_q, s_r);
        end
        @(negedge clk);
    endtask

    task automatic test_div_by_zero();
        int cyc, bc;
        exp_s_t e;
        launch_s(8'hA5, 4'd0);
        wait_s(5, cyc, bc);
        e = pop_s();
        n_tests++;
        if (s_done !== 1'b1 || cyc != 1) begin
            n_fail++; $display("FAIL dbz_latency got %0d cycles (done=%b), required 1", cyc, s_done);
        end
        n_tests++;
        if ({s_q, s_r, s_dbz} !== {e.q, e.r, e.dbz} || {s_q, s_r, s_dbz} !== {8'hFF, 4'h5, 1'b1}) begin
            n_fail++; $display("FAIL dbz_result q=%h r=%h dbz=%b, required q=ff r=5 dbz=1", s_q, s_r, s_dbz);
        end
        @(negedge clk);
        launch_s(8'd16, 4'd1);
        wait_s(20, cyc, bc);
        e = pop_s();
        n_tests++;
        if (s_done !== 1'b1 || {s_q, s_r, s_dbz} !== {e.q, e.r, e.dbz} || s_dbz !== 1'b0 || s_q !== 8'd16) begin
            n_fail++; $display("FAIL dbz_recover q=%0d r=%0d dbz=%b, required q=16 r=0 dbz=0", s_q, s_r, s_dbz);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int ndone = 0, lat = 0;
        exp_s_t e;
        launch_s(8'd77, 4'd6);
        for (int k = 1; k <= 20; k++) begin
            if (k == 3 || k == 5) begin
                s_n = 8'd250; s_d = 4'd3; s_start = 1'b1;
            end else s_start = 1'b0;
            @(negedge clk);
            if (s_done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    lat = k;
                    e = pop_s();
                    n_tests++;
                    if ({s_q, s_r, s_dbz} !== {e.q, e.r, e.dbz}) begin
                        n_fail++; $display("FAIL ignore_result q=%0d r=%0d, required q=%0d r=%0d", s_q, s_r, e.q, e.r);
                    end
                end
            end
        end
        s_start = 1'b0;
        n_tests++;
        if (ndone != 1 || lat != 8) begin
            n_fail++; $display("FAIL ignore_done saw %0d done pulses, first at %0d, required 1 at 8", ndone, lat);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, bc, ndone = 0;
        exp_s_t e;
        launch_s(8'd200, 4'd7);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({s_q, s_r, s_busy, s_done, s_dbz} !== '0) begin
            n_fail++; $display("FAIL midrun_reset q=%h r=%h busy=%b done=%b dbz=%b, required all 0",
                               s_q, s_r, s_busy, s_done, s_dbz);
        end
        sq.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (s_done === 1'b1) ndone++;
        end
        n_tests++;
        if (ndone != 0) begin
            n_fail++; $display("FAIL midrun_spurious saw %0d done pulses, required 0", ndone);
        end
        launch_s(8'd200, 4'd7);
        wait_s(20, cyc, bc);
        e = pop_s();
        n_tests++;
        if (s_done !== 1'b1 || cyc != 8 || {s_q, s_r, s_dbz} !== {e.q, e.r, e.dbz}) begin
            n_fail++; $display("FAIL midrun_restart cyc=%0d q=%0d r=%0d, required cyc=8 q=%0d r=%0d",
                               cyc, s_q, s_r, e.q, e.r);
        end
        @(negedge clk);
    endtask

    // Random pairs, each started in the done cycle of the previous one.
    task automatic test_random_small();
        int cyc, bc;
        exp_s_t e;
        launch_s(SN'($urandom_range(0, 255)), SD'($urandom_range(0, 15)));
        for (int i = 0; i < 1000; i++) begin
            wait_s(20, cyc, bc);
            e = pop_s();
            n_tests++;
            if (s_done !== 1'b1 || {s_q, s_r, s_dbz} !== {e.q, e.r, e.dbz}) begin
                n_fail++; $display("FAIL random_small[%0d] done=%b q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                                   i, s_done, s_q, s_r, s_dbz, e.q, e.r, e.dbz);
                break;
            end
            if (i < 999) launch_s(SN'($urandom_range(0, 255)), SD'($urandom_range(0, 15)));
        end
        @(negedge clk);
    endtask

    task automatic test_wide();
        logic [WN-1:0] nn, m;
        logic [WD-1:0] dd;
        exp_w_t e;
        int cyc;
        m = WN'({WD{1'b1}});
        for (int v = 0; v < 5; v++) begin
            nn = '0; dd = '0;
            repeat (33) nn = {nn[WN-33:0], 32'($urandom)};
            repeat (17) dd = {dd[WD-33:0], 32'($urandom)};
            if (v == 0) begin nn = m * m; dd = '1; end
            if (v == 1) dd = WD'(1) << (WD - 1);
            if (v == 2) dd = '1;
            if (dd == '0) dd = WD'(1);
            launch_w(nn, dd);
            wait_w(1100, cyc);
            e = pop_w();
            n_tests++;
            if (w_done !== 1'b1 || cyc != 1042) begin
                n_fail++; $display("FAIL wide_latency[%0d] got %0d cycles (done=%b), required 1042", v, cyc, w_done);
            end
            n_tests++;
            if (w_q !== e.q || w_r !== e.r || w_dbz !== 1'b0) begin
                n_fail++; $display("FAIL wide_result[%0d] q[31:0]=%h r[31:0]=%h dbz=%b, required q[31:0]=%h r[31:0]=%h dbz=0",
                                   v, w_q[31:0], w_r[31:0], w_dbz, e.q[31:0], e.r[31:0]);
            end
            if (v == 0) begin
                n_tests++;
                if (w_q !== m || w_r !== '0) begin
                    n_fail++; $display("FAIL wide_square q[31:0]=%h r[31:0]=%h, required q=2^521-1 r=0",
                                       w_q[31:0], w_r[31:0]);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_ignore_start();
        test_reset_mid_run();
        test_random_small();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
